// File: rtl/alu_exec.sv
// alu_exec: multi-cycle execute stage feeding the register file write port.
// Single-cycle logic/arithmetic, 1-bit-per-cycle shifts, 32-step shift-add multiply.
module alu_exec #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        op,
  input  logic [ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0] r_val_0,
  input  logic [DATA_W-1:0] r_val_1,
  output logic              busy,
  output logic [DATA_W-1:0] w_alu,
  output logic [ADDR_W-1:0] w_addr,
  output logic              w_enable,
  output logic [3:0]        flags,
  output logic              illegal
);

  localparam int unsigned SH_W  = $clog2(DATA_W);
  localparam int unsigned CNT_W = SH_W + 1;
  localparam int unsigned MSB   = DATA_W - 1;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_LSL = 4'd6;
  localparam logic [3:0] OP_LSR = 4'd7;
  localparam logic [3:0] OP_ASR = 4'd8;
  localparam logic [3:0] OP_MUL = 4'd9;

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state_q, state_d;
  logic                busy_d;
  logic [3:0]          op_q, op_d;
  logic [ADDR_W-1:0]   rd_q, rd_d;
  logic [DATA_W-1:0]   a_q, a_d;       // operand A / shift value / multiplicand
  logic [DATA_W-1:0]   b_q, b_d;       // operand B / multiplier
  logic [DATA_W-1:0]   acc_q, acc_d;   // multiply accumulator
  logic [CNT_W-1:0]    cnt_q, cnt_d;   // remaining iteration steps
  logic                cy_q, cy_d;     // last bit shifted out
  logic [DATA_W-1:0]   w_alu_d;
  logic [ADDR_W-1:0]   w_addr_d;
  logic                w_enable_d;
  logic [3:0]          flags_d;
  logic                illegal_d;

  logic [DATA_W:0]     sum;
  logic [DATA_W:0]     diff;
  logic [DATA_W-1:0]   res;
  logic                res_c;
  logic                res_v;
  logic                res_legal;

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      busy     <= 1'b0;
      op_q     <= '0;
      rd_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      cy_q     <= 1'b0;
      w_alu    <= '0;
      w_addr   <= '0;
      w_enable <= 1'b0;
      flags    <= '0;
      illegal  <= 1'b0;
    end else begin
      state_q  <= state_d;
      busy     <= busy_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      cy_q     <= cy_d;
      w_alu    <= w_alu_d;
      w_addr   <= w_addr_d;
      w_enable <= w_enable_d;
      flags    <= flags_d;
      illegal  <= illegal_d;
    end
  end

  // Final result and carry/overflow from the latched (or iterated) operands.
  always_comb begin
    sum       = {1'b0, a_q} + {1'b0, b_q};
    diff      = {1'b0, a_q} - {1'b0, b_q};
    res       = '0;
    res_c     = 1'b0;
    res_v     = 1'b0;
    res_legal = 1'b1;
    case (op_q)
      OP_ADD: begin
        res   = sum[MSB:0];
        res_c = sum[DATA_W];
        res_v = (a_q[MSB] == b_q[MSB]) && (sum[MSB] != a_q[MSB]);
      end
      OP_SUB: begin
        res   = diff[MSB:0];
        res_c = ~diff[DATA_W];
        res_v = (a_q[MSB] != b_q[MSB]) && (diff[MSB] != a_q[MSB]);
      end
      OP_AND: res = a_q & b_q;
      OP_OR:  res = a_q | b_q;
      OP_XOR: res = a_q ^ b_q;
      OP_NOT: res = ~a_q;
      OP_LSL, OP_LSR, OP_ASR: begin
        res   = a_q;
        res_c = cy_q;
      end
      OP_MUL: res = acc_q;
      default: res_legal = 1'b0;
    endcase
  end

  // Next-state: accept in IDLE, iterate in RUN, write back when the count runs out.
  always_comb begin
    state_d    = state_q;
    busy_d     = busy;
    op_d       = op_q;
    rd_d       = rd_q;
    a_d        = a_q;
    b_d        = b_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    cy_d       = cy_q;
    w_alu_d    = w_alu;
    w_addr_d   = w_addr;
    w_enable_d = 1'b0;
    flags_d    = flags;
    illegal_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          busy_d  = 1'b1;
          op_d    = op;
          rd_d    = rd;
          a_d     = r_val_0;
          b_d     = r_val_1;
          acc_d   = '0;
          cy_d    = 1'b0;
          case (op)
            OP_LSL, OP_LSR, OP_ASR: cnt_d = CNT_W'(r_val_1[SH_W-1:0]);
            OP_MUL:                 cnt_d = CNT_W'(DATA_W);
            default:                cnt_d = '0;
          endcase
        end
      end
      RUN: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
          case (op_q)
            OP_LSL: begin
              cy_d = a_q[MSB];
              a_d  = {a_q[MSB-1:0], 1'b0};
            end
            OP_LSR: begin
              cy_d = a_q[0];
              a_d  = {1'b0, a_q[MSB:1]};
            end
            OP_ASR: begin
              cy_d = a_q[0];
              a_d  = {a_q[MSB], a_q[MSB:1]};
            end
            OP_MUL: begin
              if (b_q[0]) acc_d = acc_q + a_q;
              a_d = {a_q[MSB-1:0], 1'b0};
              b_d = {1'b0, b_q[MSB:1]};
            end
            default: ;
          endcase
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
          if (res_legal) begin
            w_alu_d    = res;
            w_addr_d   = rd_q;
            flags_d    = {res[MSB], (res == '0), res_c, res_v};
            w_enable_d = 1'b1;
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/alu_exec.md
Name: alu_exec

Overview:
Multi-cycle execute stage between the register file read ports and its write port.
- Consumes the two read-port values r_val_0 and r_val_1 plus a decoded op and destination register.
- Computes single-cycle logic/arithmetic, iterative 1-bit-per-cycle shifts and a 32-step shift-add multiply.
- Returns the result on w_alu / w_addr / w_enable, which connect directly to the register file write port with w_select = 0 (ALU source).

Parameters:
DATA_W, 32, operand/result width (register file word width)
ADDR_W, 3, register address width (8 registers)

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  synchronous reset, active high
start  in  1  request; accepted on a rising edge when start=1 and busy=0
op  in  4  operation code, sampled at accept
rd  in  ADDR_W  destination register, sampled at accept
r_val_0  in  DATA_W  operand A, sampled at accept
r_val_1  in  DATA_W  operand B / shift amount, sampled at accept
busy  out  1  high while an accepted op is in flight
w_alu  out  DATA_W  result to register file write data
w_addr  out  ADDR_W  result destination address
w_enable  out  1  one-cycle write strobe to register file
flags  out  4  {N,Z,C,V}, updated with each w_enable
illegal  out  1  one-cycle pulse for an undefined op

Behaviour:
- Reset (rst=1 at an edge):
  - State goes to IDLE; busy=0, w_enable=0, illegal=0, w_alu=0, w_addr=0, flags=0.
  - Any in-flight op is aborted with no write.
  - A start sampled at the same edge is ignored.
  - rst has priority over every other event.
- FSM states: IDLE, RUN.
  - IDLE -> RUN on accept (edge E0): latch op, rd, A, B; load count (0 for single-cycle ops, B[4:0] for shifts, 32 for MUL).
  - RUN, count>0: perform one iteration step; count decrements.
  - RUN, count==0: register the result into w_alu, rd into w_addr, update flags, pulse w_enable; go to IDLE.
- Latency: result edge is E(L), with L = 1 + number of iterations.
  - w_enable is high for exactly the cycle following E(L).
  - busy is high from E0 to E(L).
  - start while busy is ignored; it is not queued.
  - Earliest next accept is E(L+1), i.e. start held high during the w_enable cycle is accepted.
- Operations (op):
  - 0 ADD: A+B; C = carry out; V = signed overflow.
  - 1 SUB: A-B; C = no-borrow (A>=B unsigned); V = signed overflow.
  - 2 AND, 3 OR, 4 XOR, 5 NOT A: C=0, V=0.
  - 6 LSL, 7 LSR, 8 ASR by k = B[4:0]:
    - One bit per cycle.
    - ASR fills with the sign bit.
    - C = last bit shifted out (0 if k=0).
    - V=0.
    - k=0: L=1, result=A.
  - 9 MUL: low DATA_W bits of A*B (unsigned; equals signed low word).
    - 32 shift-add steps: if mb[0] then acc += ma; ma <<= 1; mb >>= 1.
    - L=33; C=0, V=0.
  - 10-15: illegal. L=1; illegal pulses in the w_enable cycle; w_enable stays 0; w_alu, w_addr and flags are held.
- Flags:
  - N = result[DATA_W-1]; Z = (result==0).
  - Arithmetic is modulo 2^DATA_W.
- Hold rules:
  - w_alu, w_addr and flags hold their last values when w_enable=0.
  - Inputs may change freely after accept; only latched copies are used.

Test Plan:
- Reset, then start ADD with A=0x7FFFFFFF, B=1, rd=3 -> one cycle busy; w_enable one cycle; w_alu=0x80000000, w_addr=3, flags N=1 Z=0 C=0 V=1.
- SUB with A=5, B=5, rd=1 -> w_alu=0, flags Z=1 C=1 N=0 V=0 at L=1.
- ASR with A=0x80000010, B=4 -> busy 5 cycles, w_enable at L=5, w_alu=0xF8000001, C=0. LSL with A=1, B=31 -> w_alu=0x80000000, L=32. LSR with B=0 -> L=1, w_alu=A.
- MUL with A=0x00010003, B=0x00020005 -> L=33, w_alu=0x000B000F. While busy, pulse start with a different op -> ignored, no extra w_enable. Start held high during the w_enable cycle -> accepted at E(34).
- op=12 -> illegal pulse one cycle, no w_enable, w_alu unchanged.
- MUL started, then rst asserted at E10 -> busy=0 and all outputs 0 after E10; no w_enable ever appears for that op. The next op completes normally.
